mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_counter_pkg.sv | 29 ++
 rtl/tick_gen.sv | 39 +++
 rtl/mod_updown_counter.sv | 116 +++++++++++
 tb/tb_mod_updown_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_pkg
// Brief    : Shared constants and helpers for the modulo up/down counter.
//            Count-mode encodings and a decimal digit-count function used to
//            size the optional BCD output (MOD_COUNTER_BCD_OUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
package mod_counter_pkg;

    // Count direction encodings for i_up
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Number of decimal digits needed to print value (at least one)
    function automatic int digit_count(input int unsigned value);
        int          n;
        int unsigned v;
        n = 1;
        v = value;
        while (v >= 32'd10) begin
            v = v / 32'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage : mod_counter_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Prescaler. Counts enabled cycles 0..PRESCALE-1 and flags the
//            last one as a count step. Holds its phase while i_en is low.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_step
);

    // With PRESCALE=1 the phase register stays at zero and o_step collapses
    // to i_en, so the same logic serves both cases.
    localparam int                C_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [C_PW-1:0]   C_LAST = C_PW'(PRESCALE - 1);

    logic [C_PW-1:0] r_phase;

    // Phase advances on enabled cycles and wraps after the last one
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= (r_phase == C_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    assign o_step = i_en && (r_phase == C_LAST);

endmodule : tick_gen
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Modulo-(MAX_VAL+1) up/down counter with prescaler, synchronous
//            clear/load, and registered wrap/tick pulses.
//            Define MOD_COUNTER_BCD_OUT_EN to add a registered BCD view of
//            the count (o_bcd, one cycle behind o_counter).
// Revision : 1.0 - initial release
// ============================================================================
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int MAX_VAL  = 9999,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_counter,
    output logic             o_wrap,
    output logic             o_tick
`ifdef MOD_COUNTER_BCD_OUT_EN
    ,
    output logic [4*digit_count(MAX_VAL)-1:0] o_bcd
`endif
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

    logic             w_step;
    logic [WIDTH-1:0] r_counter;
    logic             r_wrap;
    logic             r_tick;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_clear   (i_clear),
        .o_step    (w_step)
    );

    // Count update with priority clear > load > step > hold
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_counter <= '0;
            r_wrap    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_clear) begin
            r_counter <= '0;
            r_wrap    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_load) begin
            // Saturate so an out-of-range load can never escape 0..MAX_VAL
            r_counter <= (i_load_val > C_MAX) ? C_MAX : i_load_val;
            r_wrap    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_step) begin
            r_tick <= 1'b1;
            if (i_up == UP) begin
                r_wrap    <= (r_counter == C_MAX);
                r_counter <= (r_counter == C_MAX) ? '0 : r_counter + 1'b1;
            end else begin
                r_wrap    <= (r_counter == '0);
                r_counter <= (r_counter == '0) ? C_MAX : r_counter - 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
            r_tick <= 1'b0;
        end
    end

    assign o_counter = r_counter;
    assign o_wrap    = r_wrap;
    assign o_tick    = r_tick;

`ifdef MOD_COUNTER_BCD_OUT_EN
    localparam int DIGITS = digit_count(MAX_VAL);

    logic [4*DIGITS-1:0] w_bcd;
    logic [4*DIGITS-1:0] r_bcd;

    // Shift-add-3 binary to BCD conversion of the current count
    always_comb begin
        w_bcd = '0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (w_bcd[4*d +: 4] >= 4'd5) begin
                    w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
                end
            end
            w_bcd = {w_bcd[4*DIGITS-2:0], r_counter[b]};
        end
    end

    // Register the converted value; lags o_counter by one cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bcd <= '0;
        end else begin
            r_bcd <= w_bcd;
        end
    end

    assign o_bcd = r_bcd;
`endif

endmodule : mod_updown_counter
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_updown_counter
// Brief    : Bench for mod_updown_counter; two instances (PRESCALE 1 and 4)
//            share one input stream. Build with MOD_COUNTER_BCD_OUT_EN to
//            include the BCD output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

    localparam int MAXV = 9999;
    localparam int PS [2] = '{1, 4};

    logic        clk;
    logic        rst_n;
    logic        en, up, clr, ld;
    logic [13:0] lv;
    logic [13:0] cnt1, cnt4;
    logic        w1, w4, t1, t4;
`ifdef MOD_COUNTER_BCD_OUT_EN
    logic [15:0] bcd1, bcd4;
`endif

    mod_updown_counter #(.WIDTH(14), .MAX_VAL(MAXV), .PRESCALE(1)) dut_p1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_up(up), .i_clear(clr),
        .i_load(ld), .i_load_val(lv), .o_counter(cnt1), .o_wrap(w1), .o_tick(t1)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .o_bcd(bcd1)
`endif
    );

    mod_updown_counter #(.WIDTH(14), .MAX_VAL(MAXV), .PRESCALE(4)) dut_p4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_up(up), .i_clear(clr),
        .i_load(ld), .i_load_val(lv), .o_counter(cnt4), .o_wrap(w4), .o_tick(t4)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .o_bcd(bcd4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c0, c1;
        int w0, w1;
        int t0, t1;
        int b0, b1;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: count value and number of enabled cycles since clear
    int m_cnt   [2];
    int m_encyc [2];
    int m_steps [2];
    int tick_seen [2];
    int wrap_seen1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp_v, exp_v, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r, x;
        r = 0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Apply one cycle of inputs and record what both counters must show next
    task automatic drive(input bit rn, input bit e, input bit u, input bit c,
                         input bit l, input int v);
        int   nc [2], nw [2], nt [2], nb [2];
        exp_t ex;
        @(negedge clk);
        rst_n = rn; en = e; up = u; clr = c; ld = l; lv = v[13:0];
        for (int k = 0; k < 2; k++) begin
            int  old;
            bit  step;
            old = m_cnt[k];
            nw[k] = 0;
            nt[k] = 0;
            if (!rn) begin
                m_cnt[k]   = 0;
                m_encyc[k] = 0;
                nb[k]      = 0;
            end else begin
                step = e && ((m_encyc[k] % PS[k]) == PS[k] - 1);
                if (c)      m_encyc[k] = 0;
                else if (e) m_encyc[k] = m_encyc[k] + 1;
                if (c) begin
                    m_cnt[k] = 0;
                end else if (l) begin
                    m_cnt[k] = (v > MAXV) ? MAXV : v;
                end else if (step) begin
                    nt[k] = 1;
                    m_steps[k]++;
                    if (u) begin
                        m_cnt[k] = (old + 1) % (MAXV + 1);
                        nw[k]    = (m_cnt[k] == 0);
                    end else begin
                        m_cnt[k] = (old + MAXV) % (MAXV + 1);
                        nw[k]    = (old == 0);
                    end
                end
                nb[k] = to_bcd(old);
            end
            nc[k] = m_cnt[k];
        end
        ex.c0 = nc[0]; ex.c1 = nc[1];
        ex.w0 = nw[0]; ex.w1 = nw[1];
        ex.t0 = nt[0]; ex.t1 = nt[1];
        ex.b0 = nb[0]; ex.b1 = nb[1];
        q.push_back(ex);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every post-edge output against the queued expectation
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                ex = q.pop_front();
                check("p1_counter", 32'(cnt1), ex.c0);
                check("p1_wrap",    32'(w1),   ex.w0);
                check("p1_tick",    32'(t1),   ex.t0);
                check("p4_counter", 32'(cnt4), ex.c1);
                check("p4_wrap",    32'(w4),   ex.w1);
                check("p4_tick",    32'(t4),   ex.t1);
`ifdef MOD_COUNTER_BCD_OUT_EN
                check("p1_bcd", 32'(bcd1), ex.b0);
                check("p4_bcd", 32'(bcd4), ex.b1);
`endif
                if (t1 === 1'b1) tick_seen[0]++;
                if (t4 === 1'b1) tick_seen[1]++;
                if (w1 === 1'b1) wrap_seen1++;
            end
        end
    end

    initial begin
        int wbase, tbase;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_encyc[k] = 0; m_steps[k] = 0; tick_seen[k] = 0;
        end
        wrap_seen1 = 0;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; lv = '0;

        // Reset state
        repeat (3) drive(0, 1, 1, 0, 0, 0);
        settle();
        check("reset_counter", 32'(cnt1), 0);
        check("reset_wrap",    32'(w1),   0);
        check("reset_tick",    32'(t1),   0);

        // Full up-count sweep 0..9999 then 0
        wbase = wrap_seen1;
        repeat (10000) drive(1, 1, 1, 0, 0, 0);
        settle();
        check("sweep_end_counter", 32'(cnt1), 0);
        check("sweep_end_wrap",    32'(w1),   1);
        check("sweep_wrap_count",  32'(wrap_seen1 - wbase), 1);

        // Down from 0 wraps to MAX then continues
        drive(1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        settle();
        check("down_wrap_counter", 32'(cnt1), MAXV);
        check("down_wrap_flag",    32'(w1),   1);
        drive(1, 1, 0, 0, 0, 0);
        settle();
        check("down_next_counter", 32'(cnt1), MAXV - 1);
        check("down_next_flag",    32'(w1),   0);

        // Prescale 4 with a hold cycle in the middle
        drive(1, 0, 1, 1, 0, 0);
        tbase = tick_seen[1];
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        settle();
        check("p4_single_step",  32'(cnt4), 1);
        check("p4_tick_count",   32'(tick_seen[1] - tbase), 1);

        // Load saturation and clear-over-load priority
        drive(1, 0, 1, 0, 1, 12000);
        settle();
        check("load_saturate", 32'(cnt1), MAXV);
        drive(1, 1, 1, 1, 1, 500);
        settle();
        check("clear_over_load", 32'(cnt1), 0);

        // Asynchronous reset in the middle of a prescale phase at 1234
        drive(1, 0, 1, 1, 0, 0);
        drive(1, 0, 1, 0, 1, 1234);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        settle();
        check("p4_premid_counter", 32'(cnt4), 1234);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_p1", 32'(cnt1), 0);
        check("async_reset_p4", 32'(cnt4), 0);
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_encyc[k] = 0;
        end
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        settle();
        check("post_reset_p1", 32'(cnt1), 1);
        repeat (3) drive(1, 1, 1, 0, 0, 0);
        settle();
        check("post_reset_p4", 32'(cnt4), 1);

`ifdef MOD_COUNTER_BCD_OUT_EN
        drive(1, 0, 1, 0, 1, 4096);
        settle();
        drive(1, 0, 1, 0, 0, 0);
        settle();
        check("bcd_4096", 32'(bcd1), 32'h4096);
`endif

        // Randomized traffic, biased toward the wrap boundaries
        for (int i = 0; i < 3000; i++) begin
            int r, v;
            bit c, l;
            r = $urandom_range(0, 99);
            c = (r < 2);
            l = (r >= 2 && r < 8);
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 16383);
                1:       v = $urandom_range(MAXV - 4, MAXV);
                default: v = $urandom_range(0, 3);
            endcase
            drive(1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), c, l, v);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 0);
        check("p1_tick_total", 32'(tick_seen[0]), 32'(m_steps[0]));
        check("p4_tick_total", 32'(tick_seen[1]), 32'(m_steps[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mod_updown_counter
`default_nettype wire
